// File: rtl/dvi_pixel_prep_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dvi_pixel_prep_pkg
//  Description : Shared video definitions for the DVI pixel preparation path:
//                pipeline latency, default counter widths and the 6-to-8 bit
//                colour expansion function.
//  Revision    : 1.0 - initial release
// ============================================================================
package dvi_pixel_prep_pkg;

   // Cycles from vicii inputs to encoder-facing outputs.
   localparam int PIPE_LAT    = 2;
   // Default widths for the timing counters.
   localparam int DEF_LEN_W   = 12;
   localparam int DEF_LINES_W = 10;

   // floor(x*255/63) computed as 4*x + floor(x/21). For a 6-bit input the
   // quotient x/21 only takes the values 0..3, so three compares replace
   // the multiply/divide.
   function automatic logic [7:0] scale6to8(input logic [5:0] x);
      logic [7:0] w_x4;
      logic [1:0] w_q;
      w_x4 = {x, 2'b00};
      if (x >= 6'd63)
         w_q = 2'd3;
      else if (x >= 6'd42)
         w_q = 2'd2;
      else if (x >= 6'd21)
         w_q = 2'd1;
      else
         w_q = 2'd0;
      return w_x4 + {6'd0, w_q};
   endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_meter.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_meter
//  Description : Measures active pixels per line and active lines per frame
//                from the stage-1 copies of active/hsync/vsync, and flags
//                when two consecutive frames report identical timing.
//                Optional macro SCANLINES_EN adds a line parity bit that
//                toggles on hsync rise and clears on vsync rise.
//  Ports       : clk_dot4x, rst         - clock, sync active-high reset
//                i_active/i_hsync/i_vsync - stage-1 video controls
//                o_line_len             - active pixels in last complete line
//                o_frame_lines          - active lines in last complete frame
//                o_timing_valid         - two matching frames seen
//                o_line_parity          - odd-line flag (0 without macro)
//  Revision    : 1.0 - initial release
// ============================================================================
module video_timing_meter
   import dvi_pixel_prep_pkg::*;
#(
   parameter int LEN_W   = DEF_LEN_W,
   parameter int LINES_W = DEF_LINES_W
)(
   input  logic               clk_dot4x,
   input  logic               rst,
   input  logic               i_active,
   input  logic               i_hsync,
   input  logic               i_vsync,
   output logic [LEN_W-1:0]   o_line_len,
   output logic [LINES_W-1:0] o_frame_lines,
   output logic               o_timing_valid,
   output logic               o_line_parity
);

   logic               r_act_prev;
   logic               r_vs_prev;
   logic [LEN_W-1:0]   r_pix_cnt;
   logic [LEN_W-1:0]   r_line_len;
   logic [LEN_W-1:0]   r_snap_len;
   logic [LINES_W-1:0] r_line_cnt;
   logic [LINES_W-1:0] r_frame_lines;
   logic               r_timing_valid;

   logic               w_act_fall;
   logic               w_vs_rise;
   logic [LINES_W-1:0] w_lines_inc;
   logic [LEN_W-1:0]   w_len_new;
   logic [LINES_W-1:0] w_lines_new;

   assign w_act_fall  = r_act_prev & ~i_active;
   assign w_vs_rise   = i_vsync & ~r_vs_prev;
   assign w_lines_inc = (r_line_cnt == '1) ? r_line_cnt : r_line_cnt + LINES_W'(1);

   // Snapshot as it will stand after this edge: a line ending in the same
   // cycle as the vsync rise still belongs to the frame being closed.
   assign w_len_new   = w_act_fall ? r_pix_cnt   : r_line_len;
   assign w_lines_new = w_act_fall ? w_lines_inc : r_line_cnt;

   always_ff @(posedge clk_dot4x) begin
      if (rst) begin
         r_act_prev     <= 1'b0;
         r_vs_prev      <= 1'b0;
         r_pix_cnt      <= '0;
         r_line_len     <= '0;
         r_snap_len     <= '0;
         r_line_cnt     <= '0;
         r_frame_lines  <= '0;
         r_timing_valid <= 1'b0;
      end else begin
         r_act_prev <= i_active;
         r_vs_prev  <= i_vsync;

         if (w_act_fall) begin
            r_line_len <= r_pix_cnt;
            r_pix_cnt  <= '0;
         end else if (i_active && (r_pix_cnt != '1)) begin
            r_pix_cnt <= r_pix_cnt + LEN_W'(1);
         end

         if (w_vs_rise) begin
            // r_frame_lines doubles as the previous frame's line snapshot.
            r_timing_valid <= (w_len_new == r_snap_len) &&
                              (w_lines_new == r_frame_lines) &&
                              (w_lines_new != '0);
            r_snap_len     <= w_len_new;
            r_frame_lines  <= w_lines_new;
            r_line_cnt     <= '0;
         end else if (w_act_fall) begin
            r_line_cnt <= w_lines_inc;
         end
      end
   end

   assign o_line_len     = r_line_len;
   assign o_frame_lines  = r_frame_lines;
   assign o_timing_valid = r_timing_valid;

`ifdef SCANLINES_EN
   logic r_hs_prev;
   logic r_parity;
   logic w_hs_rise;

   assign w_hs_rise = i_hsync & ~r_hs_prev;

   always_ff @(posedge clk_dot4x) begin
      if (rst) begin
         r_hs_prev <= 1'b0;
         r_parity  <= 1'b0;
      end else begin
         r_hs_prev <= i_hsync;
         if (w_vs_rise)
            r_parity <= 1'b0;
         else if (w_hs_rise)
            r_parity <= ~r_parity;
      end
   end

   assign o_line_parity = r_parity;
`else
   logic w_unused_hsync;
   assign w_unused_hsync = i_hsync;
   assign o_line_parity  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/dvi_pixel_prep.sv
`default_nettype none
// ============================================================================
//  Module      : dvi_pixel_prep
//  Description : Pipeline stage between vicii RGB/sync and the DVI encoder.
//                Expands 6-bit colour to 8-bit, blanks outside the active
//                region, delays syncs/de by the same two cycles, and reports
//                measured video timing. Optional macro SCANLINES_EN halves
//                the intensity of every other line.
//  Ports       : clk_dot4x, rst               - clock, sync active-high reset
//                red_i/green_i/blue_i [5:0]   - vicii colour
//                hsync_i/vsync_i/active_i     - vicii syncs and display enable
//                red_o/green_o/blue_o [7:0]   - scaled colour to encoder
//                hsync_o/vsync_o/de_o         - syncs and de, 2-cycle delay
//                line_len/frame_lines         - measured timing
//                timing_valid                 - two matching frames seen
//  Revision    : 1.0 - initial release
// ============================================================================
module dvi_pixel_prep
   import dvi_pixel_prep_pkg::*;
#(
   parameter int LEN_W   = DEF_LEN_W,
   parameter int LINES_W = DEF_LINES_W
)(
   input  logic               clk_dot4x,
   input  logic               rst,
   input  logic [5:0]         red_i,
   input  logic [5:0]         green_i,
   input  logic [5:0]         blue_i,
   input  logic               hsync_i,
   input  logic               vsync_i,
   input  logic               active_i,
   output logic [7:0]         red_o,
   output logic [7:0]         green_o,
   output logic [7:0]         blue_o,
   output logic               hsync_o,
   output logic               vsync_o,
   output logic               de_o,
   output logic [LEN_W-1:0]   line_len,
   output logic [LINES_W-1:0] frame_lines,
   output logic               timing_valid
);

   // Stage 1: plain input registers.
   logic [5:0] r_red1;
   logic [5:0] r_green1;
   logic [5:0] r_blue1;
   logic       r_hs1;
   logic       r_vs1;
   logic       r_act1;

   always_ff @(posedge clk_dot4x) begin
      if (rst) begin
         r_red1   <= '0;
         r_green1 <= '0;
         r_blue1  <= '0;
         r_hs1    <= 1'b0;
         r_vs1    <= 1'b0;
         r_act1   <= 1'b0;
      end else begin
         r_red1   <= red_i;
         r_green1 <= green_i;
         r_blue1  <= blue_i;
         r_hs1    <= hsync_i;
         r_vs1    <= vsync_i;
         r_act1   <= active_i;
      end
   end

   logic       w_line_parity;
   logic [7:0] w_red_s;
   logic [7:0] w_green_s;
   logic [7:0] w_blue_s;
   logic [7:0] w_red_px;
   logic [7:0] w_green_px;
   logic [7:0] w_blue_px;

   assign w_red_s   = scale6to8(r_red1);
   assign w_green_s = scale6to8(r_green1);
   assign w_blue_s  = scale6to8(r_blue1);

   // Scanline dimming; parity is held at 0 when the feature is compiled out.
   assign w_red_px   = w_line_parity ? {1'b0, w_red_s[7:1]}   : w_red_s;
   assign w_green_px = w_line_parity ? {1'b0, w_green_s[7:1]} : w_green_s;
   assign w_blue_px  = w_line_parity ? {1'b0, w_blue_s[7:1]}  : w_blue_s;

   // Stage 2: scale, blank on stage-1 active, register outputs.
   always_ff @(posedge clk_dot4x) begin
      if (rst) begin
         red_o   <= '0;
         green_o <= '0;
         blue_o  <= '0;
         hsync_o <= 1'b0;
         vsync_o <= 1'b0;
         de_o    <= 1'b0;
      end else begin
         red_o   <= r_act1 ? w_red_px   : 8'd0;
         green_o <= r_act1 ? w_green_px : 8'd0;
         blue_o  <= r_act1 ? w_blue_px  : 8'd0;
         hsync_o <= r_hs1;
         vsync_o <= r_vs1;
         de_o    <= r_act1;
      end
   end

   video_timing_meter #(
      .LEN_W   (LEN_W),
      .LINES_W (LINES_W)
   ) u_meter (
      .clk_dot4x      (clk_dot4x),
      .rst            (rst),
      .i_active       (r_act1),
      .i_hsync        (r_hs1),
      .i_vsync        (r_vs1),
      .o_line_len     (line_len),
      .o_frame_lines  (frame_lines),
      .o_timing_valid (timing_valid),
      .o_line_parity  (w_line_parity)
   );

endmodule
`default_nettype wire

// File: tb/tb_dvi_pixel_prep.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dvi_pixel_prep
//  Description : Self-checking bench for dvi_pixel_prep: table of pixel-path
//                vectors plus hand-written frame/timing sequences. With
//                SCANLINES_EN defined, an extra scanline sequence is run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dvi_pixel_prep;

   logic        clk_dot4x = 1'b0;
   logic        rst;
   logic [5:0]  red_i, green_i, blue_i;
   logic        hsync_i, vsync_i, active_i;
   logic [7:0]  red_o, green_o, blue_o;
   logic        hsync_o, vsync_o, de_o;
   logic [11:0] line_len;
   logic [9:0]  frame_lines;
   logic        timing_valid;

   int checks = 0;
   int errors = 0;

   always #5 clk_dot4x = ~clk_dot4x;

   dvi_pixel_prep #(.LEN_W(12), .LINES_W(10)) dut (
      .clk_dot4x    (clk_dot4x),
      .rst          (rst),
      .red_i        (red_i),
      .green_i      (green_i),
      .blue_i       (blue_i),
      .hsync_i      (hsync_i),
      .vsync_i      (vsync_i),
      .active_i     (active_i),
      .red_o        (red_o),
      .green_o      (green_o),
      .blue_o       (blue_o),
      .hsync_o      (hsync_o),
      .vsync_o      (vsync_o),
      .de_o         (de_o),
      .line_len     (line_len),
      .frame_lines  (frame_lines),
      .timing_valid (timing_valid)
   );

   typedef struct {
      logic [5:0] r, g, b;
      logic       hs, act;
      logic [7:0] er, eg, eb;
   } vec_t;

   localparam int NVEC = 71;
   vec_t vecs [NVEC];

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_dot4x);
         #1;
      end
   endtask

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   // One frame: per line hsync pulse, then px active cycles. With sim_end the
   // last line's active fall coincides with the vsync rise.
   task automatic frame(input int lines, input int px, input bit sim_end);
      red_i = 6'd10; green_i = 6'd20; blue_i = 6'd30;
      for (int l = 0; l < lines; l++) begin
         hsync_i = 1'b1; tick(2);
         hsync_i = 1'b0; tick(1);
         active_i = 1'b1; tick(px);
         if (sim_end && (l == lines - 1)) begin
            active_i = 1'b0; vsync_i = 1'b1; tick(3);
            vsync_i = 1'b0; tick(2);
            return;
         end
         active_i = 1'b0; tick(2);
      end
      vsync_i = 1'b1; tick(3);
      vsync_i = 1'b0; tick(2);
   endtask

`ifdef SCANLINES_EN
   task automatic scan_line(input string name, input int unsigned exp);
      active_i = 1'b1; tick(3);
      chk(name, red_o, exp);
      active_i = 1'b0; tick(3);
   endtask

   task automatic hs_pulse();
      hsync_i = 1'b1; tick(2);
      hsync_i = 1'b0; tick(2);
   endtask
`endif

   initial begin
      // ---------------- vector table ----------------
      vecs[0] = '{r:6'd63, g:6'd32, b:6'd1, hs:1'b0, act:1'b1, er:8'd255, eg:8'd129, eb:8'd4};
      for (int x = 0; x < 64; x++) begin
         int unsigned e;
         e = (x * 255) / 63;
         vecs[1 + x] = '{r:6'(x), g:6'(x), b:6'(x), hs:1'b0, act:1'b1,
                         er:8'(e), eg:8'(e), eb:8'(e)};
      end
      begin
         logic [5:0] hs_pat;
         hs_pat = 6'b101101;
         for (int k = 0; k < 6; k++)
            vecs[65 + k] = '{r:6'd63, g:6'd63, b:6'd63, hs:hs_pat[k], act:1'b0,
                             er:8'd0, eg:8'd0, eb:8'd0};
      end

      // ---------------- reset state ----------------
      red_i = 6'd63; green_i = 6'd63; blue_i = 6'd63;
      hsync_i = 1'b1; vsync_i = 1'b1; active_i = 1'b1;
      rst = 1'b1;
      tick(3);
      chk("rst_red",   red_o, 0);
      chk("rst_green", green_o, 0);
      chk("rst_blue",  blue_o, 0);
      chk("rst_hs",    hsync_o, 0);
      chk("rst_vs",    vsync_o, 0);
      chk("rst_de",    de_o, 0);
      chk("rst_len",   line_len, 0);
      chk("rst_lines", frame_lines, 0);
      chk("rst_valid", timing_valid, 0);
      hsync_i = 1'b0; vsync_i = 1'b0; active_i = 1'b0;
      tick(1);
      rst = 1'b0;
      tick(2);

      // ---------------- pixel path table, 2-cycle latency ----------------
      for (int i = 0; i <= NVEC; i++) begin
         if (i < NVEC) begin
            red_i = vecs[i].r; green_i = vecs[i].g; blue_i = vecs[i].b;
            hsync_i = vecs[i].hs; active_i = vecs[i].act;
         end else begin
            active_i = 1'b0; hsync_i = 1'b0;
         end
         tick(1);
         if (i >= 1) begin
            chk($sformatf("vec%0d_red", i - 1),   red_o,   vecs[i - 1].er);
            chk($sformatf("vec%0d_green", i - 1), green_o, vecs[i - 1].eg);
            chk($sformatf("vec%0d_blue", i - 1),  blue_o,  vecs[i - 1].eb);
            chk($sformatf("vec%0d_hs", i - 1),    hsync_o, vecs[i - 1].hs);
            chk($sformatf("vec%0d_de", i - 1),    de_o,    vecs[i - 1].act);
         end
      end

      // ---------------- vsync latency ----------------
      tick(2);
      vsync_i = 1'b1; tick(1);
      chk("vs_lat1", vsync_o, 0);
      tick(1);
      chk("vs_lat2", vsync_o, 1);
      vsync_i = 1'b0; tick(1);
      chk("vs_hold", vsync_o, 1);
      tick(1);
      chk("vs_fall", vsync_o, 0);

      // ---------------- timing measurement ----------------
      do_reset();
      frame(20, 40, 1'b0);
      chk("f1_len",   line_len, 40);
      chk("f1_lines", frame_lines, 20);
      chk("f1_valid", timing_valid, 0);
      frame(20, 40, 1'b0);
      chk("f2_len",   line_len, 40);
      chk("f2_lines", frame_lines, 20);
      chk("f2_valid", timing_valid, 1);
      frame(19, 40, 1'b0);
      chk("f3_lines", frame_lines, 19);
      chk("f3_valid", timing_valid, 0);

      // ---------------- reset mid-line ----------------
      red_i = 6'd63; active_i = 1'b1; tick(10);
      rst = 1'b1; tick(2);
      chk("mid_red",   red_o, 0);
      chk("mid_de",    de_o, 0);
      chk("mid_len",   line_len, 0);
      chk("mid_lines", frame_lines, 0);
      chk("mid_valid", timing_valid, 0);
      active_i = 1'b0; rst = 1'b0; tick(3);
      frame(20, 40, 1'b0);
      chk("r1_len",   line_len, 40);
      chk("r1_lines", frame_lines, 20);
      chk("r1_valid", timing_valid, 0);
      frame(20, 40, 1'b0);
      chk("r2_valid", timing_valid, 1);

      // ---------------- active fall coincident with vsync rise ----------------
      frame(3, 5, 1'b1);
      chk("sim_len",   line_len, 5);
      chk("sim_lines", frame_lines, 3);
      chk("sim_valid", timing_valid, 0);

`ifdef SCANLINES_EN
      // ---------------- scanline dimming ----------------
      do_reset();
      red_i = 6'd63; green_i = 6'd63; blue_i = 6'd63;
      hsync_i = 1'b0; vsync_i = 1'b0; active_i = 1'b0;
      tick(2);
      scan_line("scan_l0", 255);
      hs_pulse();
      scan_line("scan_l1", 127);
      hs_pulse();
      scan_line("scan_l2", 255);
      hs_pulse();
      scan_line("scan_l3", 127);
      vsync_i = 1'b1; tick(3);
      vsync_i = 1'b0; tick(2);
      scan_line("scan_vs0", 255);
      hs_pulse();
      scan_line("scan_vs1", 127);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
